// File: rtl/convolutor_pkg.sv
// convolutor_pkg: shared state encoding and default operand width; PARITY state exists only under PARITY_EN
package convolutor_pkg;
  localparam int WORD_W_DEF = 6;
  typedef enum logic [2:0] {
    IDLE,
    RECV_A,
    RECV_B,
`ifdef PARITY_EN
    PARITY,
`endif
    HOLD
  } state_t;
endpackage

// File: rtl/serial_in_shifter.sv
// serial_in_shifter: LSB-first shift register, new bit enters at the MSB, with synchronous clear
module serial_in_shifter #(
  parameter int W = 6
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic         din,
  output logic [W-1:0] q
);
  // clear wins over shift so a restart always begins from an empty word
  always_ff @(posedge clock or posedge reset)
    if (reset) q <= '0;
    else if (clr) q <= '0;
    else if (en) q <= {din, q[W-1:1]};
endmodule

// File: rtl/operand_deserializer.sv
// operand_deserializer: collects two serial LSB-first operands into a registered A/B pair; PARITY_EN adds a trailing even-parity bit
module operand_deserializer
  import convolutor_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              sin,
  input  logic              sin_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] A,
  output logic [WORD_W-1:0] B,
  output logic              out_valid,
  output logic              busy,
  output logic              frame_err
);
  localparam int CW = $clog2(WORD_W + 1);
  state_t state, next;
  logic [CW-1:0] cnt;
  logic [WORD_W-1:0] sa, sb, b_new;
  logic restart, take, last, en_a, en_b, load, par_ok, par_bad;
  assign restart = start && state != HOLD;
  assign take = (state == RECV_A || state == RECV_B) && sin_valid && !start;
  assign last = take && cnt == CW'(WORD_W - 1);
  assign par_ok = ~^{sa, sb, sin};
  serial_in_shifter #(.W(WORD_W)) u_sh_a (.clock(clock), .reset(reset), .clr(restart), .en(en_a), .din(sin), .q(sa));
  serial_in_shifter #(.W(WORD_W)) u_sh_b (.clock(clock), .reset(reset), .clr(restart), .en(en_b), .din(sin), .q(sb));
  // state register
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= next;
  // next-state: start restarts any receiving state, HOLD waits for the handshake
  always_comb begin
    next = state;
    case (state)
      IDLE:   next = start ? RECV_A : IDLE;
      RECV_A: next = start ? RECV_A : last ? RECV_B : RECV_A;
`ifdef PARITY_EN
      RECV_B: next = start ? RECV_A : last ? PARITY : RECV_B;
      PARITY: next = start ? RECV_A : !sin_valid ? PARITY : par_ok ? HOLD : IDLE;
`else
      RECV_B: next = start ? RECV_A : last ? HOLD : RECV_B;
`endif
      HOLD:   next = out_ready ? IDLE : HOLD;
      default: next = IDLE;
    endcase
  end
  // outputs and datapath controls decoded from the current state
  always_comb begin
    busy = state != IDLE;
    out_valid = state == HOLD;
    en_a = take && state == RECV_A;
    en_b = take && state == RECV_B;
`ifdef PARITY_EN
    load = state == PARITY && sin_valid && !start && par_ok;
    par_bad = state == PARITY && sin_valid && !start && !par_ok;
    b_new = sb;
`else
    load = last && state == RECV_B;
    par_bad = 1'b0;
    b_new = {sin, sb[WORD_W-1:1]};
`endif
  end
  // bit counter restarts at every word boundary and on every restart
  always_ff @(posedge clock or posedge reset)
    if (reset) cnt <= '0;
    else if (restart || last) cnt <= '0;
    else if (take) cnt <= cnt + 1'b1;
  // A/B change only when a complete, accepted frame is loaded
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      A <= '0;
      B <= '0;
    end else if (load) begin
      A <= sa;
      B <= b_new;
    end
`ifdef PARITY_EN
  // one-cycle pulse on a parity mismatch
  always_ff @(posedge clock or posedge reset)
    if (reset) frame_err <= 1'b0;
    else frame_err <= par_bad;
`else
  assign frame_err = par_bad;
`endif
endmodule

// File: tb/tb_operand_deserializer.sv
// tb_operand_deserializer: directed self-checking bench for operand_deserializer
module tb_operand_deserializer;
  logic clock = 0, reset = 0, start = 0, sin = 0, sin_valid = 0, out_ready = 0;
  logic [5:0] A, B;
  logic out_valid, busy, frame_err;
  int checks = 0, passes = 0;

  operand_deserializer dut (
    .clock(clock), .reset(reset), .start(start), .sin(sin), .sin_valid(sin_valid),
    .out_ready(out_ready), .A(A), .B(B), .out_valid(out_valid), .busy(busy), .frame_err(frame_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passes++;
  endtask

  task automatic pulse_start();
    start = 1; sin = 1; sin_valid = 1;
    @(negedge clock);
    start = 0; sin_valid = 0;
  endtask

  task automatic send_bit(input logic b, input int gap);
    sin = b; sin_valid = 1;
    @(negedge clock);
    sin_valid = 0;
    repeat (gap) @(negedge clock);
  endtask

  // sends all bits except the last B bit, leaving it on sin with sin_valid=1
  task automatic send_frame_but_last(input logic [5:0] a, input logic [5:0] b, input logic gaps);
    for (int i = 0; i < 6; i++) send_bit(a[i], gaps ? (i % 3) + 1 : 0);
    for (int i = 0; i < 5; i++) send_bit(b[i], gaps ? ((i + 1) % 3) + 1 : 0);
    sin = b[5]; sin_valid = 1;
  endtask

  task automatic handshake();
    out_ready = 1;
    @(negedge clock);
    out_ready = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (2) @(negedge clock);
    chk("reset_A", A, 6'h00);
    chk("reset_B", B, 6'h00);
    chk("reset_out_valid", 6'(out_valid), 6'd0);
    chk("reset_busy", 6'(busy), 6'd0);
    chk("reset_frame_err", 6'(frame_err), 6'd0);
    reset = 0;
    @(negedge clock);
  endtask

  task automatic test_frame();
    pulse_start();
    chk("frame_busy", 6'(busy), 6'd1);
    send_frame_but_last(6'h2D, 6'h33, 0);
    chk("frame_valid_before_last", 6'(out_valid), 6'd0);
    @(negedge clock);
    sin_valid = 0;
    chk("frame_out_valid", 6'(out_valid), 6'd1);
    chk("frame_A", A, 6'h2D);
    chk("frame_B", B, 6'h33);
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      sin_valid = (i == 3);
      @(negedge clock);
      start = 0; sin_valid = 0;
      chk("bp_out_valid", 6'(out_valid), 6'd1);
      chk("bp_A", A, 6'h2D);
      chk("bp_B", B, 6'h33);
    end
    handshake();
    chk("bp_out_valid_after", 6'(out_valid), 6'd0);
    chk("bp_busy_after", 6'(busy), 6'd0);
    sin = 1; sin_valid = 1;
    repeat (3) @(negedge clock);
    sin_valid = 0;
    chk("idle_sin_ignored_busy", 6'(busy), 6'd0);
    chk("idle_A_kept", A, 6'h2D);
  endtask

  task automatic test_restart();
    pulse_start();
    for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
    pulse_start();
    chk("restart_frame_err", 6'(frame_err), 6'd0);
    chk("restart_A_kept", A, 6'h2D);
    send_frame_but_last(6'h01, 6'h3F, 0);
    @(negedge clock);
    sin_valid = 0;
    chk("restart_out_valid", 6'(out_valid), 6'd1);
    chk("restart_A", A, 6'h01);
    chk("restart_B", B, 6'h3F);
    chk("restart_frame_err_end", 6'(frame_err), 6'd0);
    handshake();
  endtask

  task automatic test_gaps();
    pulse_start();
    send_frame_but_last(6'h2D, 6'h33, 1);
    chk("gap_valid_before_last", 6'(out_valid), 6'd0);
    @(negedge clock);
    sin_valid = 0;
    chk("gap_out_valid", 6'(out_valid), 6'd1);
    chk("gap_A", A, 6'h2D);
    chk("gap_B", B, 6'h33);
    handshake();
    chk("gap_busy_after", 6'(busy), 6'd0);
  endtask

  task automatic test_reset_mid();
    pulse_start();
    for (int i = 0; i < 8; i++) send_bit(i[0], 0);
    #2 reset = 1;
    #1;
    chk("mid_reset_A", A, 6'h00);
    chk("mid_reset_B", B, 6'h00);
    chk("mid_reset_busy", 6'(busy), 6'd0);
    chk("mid_reset_out_valid", 6'(out_valid), 6'd0);
    chk("mid_reset_frame_err", 6'(frame_err), 6'd0);
    @(negedge clock);
    reset = 0;
    @(negedge clock);
    pulse_start();
    send_frame_but_last(6'h2D, 6'h33, 0);
    @(negedge clock);
    sin_valid = 0;
    chk("post_reset_out_valid", 6'(out_valid), 6'd1);
    chk("post_reset_A", A, 6'h2D);
    chk("post_reset_B", B, 6'h33);
    handshake();
  endtask

`ifdef PARITY_EN
  task automatic test_parity();
    pulse_start();
    send_frame_but_last(6'h2D, 6'h33, 0);
    @(negedge clock);
    send_bit(1'b0, 0);
    chk("par_ok_out_valid", 6'(out_valid), 6'd1);
    chk("par_ok_frame_err", 6'(frame_err), 6'd0);
    handshake();
    pulse_start();
    send_frame_but_last(6'h01, 6'h3E, 0);
    @(negedge clock);
    send_bit(1'b1, 0);
    chk("par_bad_frame_err", 6'(frame_err), 6'd1);
    chk("par_bad_out_valid", 6'(out_valid), 6'd0);
    chk("par_bad_A", A, 6'h2D);
    chk("par_bad_B", B, 6'h33);
    @(negedge clock);
    chk("par_bad_pulse_end", 6'(frame_err), 6'd0);
    chk("par_bad_busy", 6'(busy), 6'd0);
  endtask
`endif

  initial begin
    @(negedge clock);
    test_reset();
    test_frame();
    test_backpressure();
    test_restart();
    test_gaps();
    test_reset_mid();
`ifdef PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/operand_deserializer.md
OPERAND_DESERIALIZER -- requirements
Module: operand_deserializer

Interface
REQ-001 SHALL have parameter: WORD_W, 6, width of each operand word.
REQ-002 SHALL have port: clock  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  frame-begin strobe.
REQ-005 SHALL have port: sin  input  1  serial data bit.
REQ-006 SHALL have port: sin_valid  input  1  sin is sampled this cycle.
REQ-007 SHALL have port: out_ready  input  1  consumer accepts the A/B pair.
REQ-008 SHALL have port: A  output  WORD_W  assembled first operand, registered.
REQ-009 SHALL have port: B  output  WORD_W  assembled second operand, registered.
REQ-010 SHALL have port: out_valid  output  1  A/B pair available.
REQ-011 SHALL have port: busy  output  1  high whenever state is not IDLE.
REQ-012 SHALL have port: frame_err  output  1  one-cycle parity-failure pulse.

Function
REQ-013 SHALL implement states IDLE, RECV_A, RECV_B, PARITY (only when PARITY_EN is defined) and HOLD.
REQ-014 In IDLE, start=1 SHALL move to RECV_A with the bit counter cleared; sin in the start cycle SHALL be ignored.
REQ-015 In RECV_A and RECV_B, the block SHALL accept one bit per cycle with sin_valid=1, LSB first: shift right, new bit into the MSB; cycles with sin_valid=0 SHALL hold all state.
REQ-016 After WORD_W accepted bits, RECV_A SHALL go to RECV_B and the counter SHALL clear.
REQ-017 After WORD_W accepted bits in RECV_B, the block SHALL load A/B and go to HOLD (or to PARITY if enabled); out_valid SHALL rise on the next clock edge after the last bit, a latency of 1 cycle.
REQ-018 In HOLD, out_valid SHALL be 1 and A/B SHALL be stable until out_valid&&out_ready; that handshake cycle SHALL return to IDLE and out_valid SHALL be 0 the following cycle.
REQ-019 start in RECV_A, RECV_B or PARITY SHALL restart at RECV_A, discarding partial data without frame_err; start in HOLD SHALL be ignored.
REQ-020 sin_valid outside the RECV and PARITY states SHALL be ignored.
REQ-021 A and B SHALL change only on a successful frame load and SHALL otherwise keep their last values.

Reset
REQ-022 reset SHALL immediately force IDLE, clear the counter and shift registers, and drive A=0, B=0, out_valid=0, busy=0, frame_err=0, including mid-frame.

Configuration
REQ-023 With macro PARITY_EN defined, after B the next sin_valid bit SHALL be an even-parity bit over all 2*WORD_W data bits plus parity.
REQ-024 With PARITY_EN defined, a parity match SHALL load A/B and go to HOLD; a mismatch SHALL pulse frame_err for 1 cycle, leave A/B unchanged, keep out_valid at 0 and return to IDLE.
REQ-025 Without PARITY_EN, the PARITY state SHALL not exist and frame_err SHALL be tied to 0.

Structure
REQ-026 Shared package convolutor_pkg SHALL hold the state enum typedef and the default WORD_W constant.
REQ-027 A single sub-module serial_in_shifter (WORD_W-wide, with load-clear and shift-enable) SHALL be instantiated twice, once for A and once for B.

Verification
REQ-028 Frame test: start, then bits of A=0x2D and B=0x33 LSB first on consecutive cycles -> out_valid=1 the cycle after the 12th bit, with A=0x2D and B=0x33.
REQ-029 Backpressure test: out_ready=0 for 5 cycles in HOLD -> A/B/out_valid stable; out_ready=1 for 1 cycle -> IDLE, busy=0 next cycle.
REQ-030 Gap test: the same frame with sin_valid=0 gaps of 1-3 cycles between bits -> identical result, A=0x2D, B=0x33.
REQ-031 Restart test: start, 4 bits, start again, then a full frame A=0x01, B=0x3F -> A=0x01, B=0x3F, frame_err=0.
REQ-032 Reset test: reset asserted after 8 bits -> all outputs 0 immediately; next full frame decodes correctly.
REQ-033 Parity test (PARITY_EN): A=0x2D, B=0x33 with parity bit 0 -> out_valid=1; with parity bit 1 -> frame_err pulse of 1 cycle, out_valid stays 0, A/B keep their previous values.
